// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the memory access controller slice.
// The optional write read-back check is enabled with MEM_WRITE_VERIFY_EN.
package mem_ctrl_pkg;

  localparam int ADDR_W_DEF = 9;
  localparam int DATA_W_DEF = 32;
  localparam int CNT_W      = 4;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    VERIFY = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable down-counter with a zero flag, used to time read wait states.
module mem_wait_counter
  import mem_ctrl_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count_r;

  // Load takes priority over decrement; the counter saturates at zero
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= {W{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (dec && (count_r != {W{1'b0}})) begin
      count_r <= count_r - {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == {W{1'b0}});

endmodule

// File: rtl/mem_access_ctrl.sv
// CPU-side initiator for the word-addressed memory: owns MAR/MDR and sequences one access at a time.
// Build option: define MEM_WRITE_VERIFY_EN to add a one-cycle read-back compare after each write.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic              verify_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_datain,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_dataout
);

  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

  state_t            state_r;
  logic [ADDR_W-1:0] mar_r;
  logic [DATA_W-1:0] wdata_r;
  logic [DATA_W-1:0] mdr_r;
  logic              op_wr_r;
  logic              busy_r;
  logic              done_r;
  logic              cnt_load_s;
  logic              cnt_dec_s;
  logic              cnt_zero_s;

  // Wait-state counter control: load on accept, count down only during a read access
  always_comb begin
    cnt_load_s = 1'b0;
    cnt_dec_s  = 1'b0;
    if ((state_r == IDLE) && start) begin
      cnt_load_s = 1'b1;
    end else begin
      cnt_load_s = 1'b0;
    end
    if ((state_r == ACCESS) && (op_wr_r == OP_RD) && !cnt_zero_s) begin
      cnt_dec_s = 1'b1;
    end else begin
      cnt_dec_s = 1'b0;
    end
  end

  mem_wait_counter #(.W(CNT_W)) u_wait_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load_s),
    .dec      (cnt_dec_s),
    .load_val (WAIT_INIT),
    .zero     (cnt_zero_s)
  );

  // Request sequencer with MAR/MDR and registered handshake outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      mar_r   <= {ADDR_W{1'b0}};
      wdata_r <= {DATA_W{1'b0}};
      mdr_r   <= {DATA_W{1'b0}};
      op_wr_r <= OP_RD;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            mar_r   <= addr_in;
            op_wr_r <= wr;
            wdata_r <= wdata;
            busy_r  <= 1'b1;
            state_r <= ACCESS;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        ACCESS: begin
          if (op_wr_r == OP_WR) begin
`ifdef MEM_WRITE_VERIFY_EN
            state_r <= VERIFY;
            done_r  <= 1'b0;
`else
            state_r <= DONE;
            done_r  <= 1'b1;
`endif
          end else if (cnt_zero_s) begin
            mdr_r   <= mem_dataout;
            state_r <= DONE;
            done_r  <= 1'b1;
          end else begin
            state_r <= ACCESS;
            done_r  <= 1'b0;
          end
        end
`ifdef MEM_WRITE_VERIFY_EN
        VERIFY: begin
          state_r <= DONE;
          done_r  <= 1'b1;
        end
`endif
        DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

`ifdef MEM_WRITE_VERIFY_EN
  logic verify_err_r;

  // Sticky read-back mismatch flag, cleared by the next accepted request
  always_ff @(posedge clk) begin
    if (reset) begin
      verify_err_r <= 1'b0;
    end else if ((state_r == IDLE) && start) begin
      verify_err_r <= 1'b0;
    end else if ((state_r == VERIFY) && (mem_dataout != wdata_r)) begin
      verify_err_r <= 1'b1;
    end else begin
      verify_err_r <= verify_err_r;
    end
  end

  assign verify_err = verify_err_r;
`else
  assign verify_err = 1'b0;
`endif

  // Write strobe is gated by reset so nothing commits on a reset edge
  assign mem_write  = (state_r == ACCESS) && (op_wr_r == OP_WR) && !reset;
  assign mem_addr   = mar_r;
  assign mem_datain = wdata_r;
  assign rdata      = mdr_r;
  assign busy       = busy_r;
  assign done       = done_r;

endmodule
